// File: rtl/pkt_ingress_classifier.sv
// rtl/pkt_ingress_classifier.sv - classifies ingress packets on the first beat into DATA/CTRL/DROP.
// Each output port has a single register stage, and the block keeps per-class packet counters.
module pkt_ingress_classifier #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] CTRL_UDP_PORT        = 16'hf1f2,
  parameter int          CNT_WIDTH            = 32
) (
  input  logic                              clk,
  input  logic                              areset,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,

  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_data_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_data_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_data_axis_tuser,
  output logic                              m_data_axis_tvalid,
  output logic                              m_data_axis_tlast,
  input  logic                              m_data_axis_tready,

  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_ctrl_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_ctrl_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_ctrl_axis_tuser,
  output logic                              m_ctrl_axis_tvalid,
  output logic                              m_ctrl_axis_tlast,
  input  logic                              m_ctrl_axis_tready,

  output logic [CNT_WIDTH-1:0]              data_pkt_cnt,
  output logic [CNT_WIDTH-1:0]              ctrl_pkt_cnt,
  output logic [CNT_WIDTH-1:0]              drop_pkt_cnt
);

  typedef enum logic [1:0] {IDLE, FWD_DATA, FWD_CTRL, DROP} state_e;
  typedef enum logic [1:0] {CLS_DATA, CLS_CTRL, CLS_DROP} cls_e;

  state_e state, next_state;
  cls_e   sop_cls, cur_cls;

  logic [15:0] ethertype, inner_type, udp_dport;
  logic [7:0]  ip_proto;
  logic        sop, accept, data_load, ctrl_load;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] fwd_tuser;

  assign ethertype  = {s_axis_tdata[12*8 +: 8], s_axis_tdata[13*8 +: 8]};
  assign inner_type = {s_axis_tdata[16*8 +: 8], s_axis_tdata[17*8 +: 8]};
  assign ip_proto   = s_axis_tdata[27*8 +: 8];
  assign udp_dport  = {s_axis_tdata[40*8 +: 8], s_axis_tdata[41*8 +: 8]};

  always_comb begin
    sop_cls = CLS_DROP;
    if (ethertype == 16'h8100) begin
      if (inner_type == 16'h0800 && ip_proto == 8'h11 && udp_dport == CTRL_UDP_PORT)
        sop_cls = CLS_CTRL;
      else
        sop_cls = CLS_DATA;
    end
  end

  // The class is latched in the FSM state, so later beats never get re-decoded.
  always_comb begin
    cur_cls = CLS_DROP;
    case (state)
      IDLE:     cur_cls = sop_cls;
      FWD_DATA: cur_cls = CLS_DATA;
      FWD_CTRL: cur_cls = CLS_CTRL;
      default:  cur_cls = CLS_DROP;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    if (!areset) begin
      case (cur_cls)
        CLS_DATA: s_axis_tready = ~m_data_axis_tvalid | m_data_axis_tready;
        CLS_CTRL: s_axis_tready = ~m_ctrl_axis_tvalid | m_ctrl_axis_tready;
        default:  s_axis_tready = 1'b1;
      endcase
    end
  end

  assign sop       = (state == IDLE);
  assign accept    = s_axis_tvalid & s_axis_tready;
  assign data_load = accept & (cur_cls == CLS_DATA);
  assign ctrl_load = accept & (cur_cls == CLS_CTRL);
  assign fwd_tuser = sop ? s_axis_tuser : '0;

  always_comb begin
    next_state = state;
    if (accept) begin
      if (s_axis_tlast)
        next_state = IDLE;
      else if (state == IDLE) begin
        case (sop_cls)
          CLS_DATA: next_state = FWD_DATA;
          CLS_CTRL: next_state = FWD_CTRL;
          default:  next_state = DROP;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (areset) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      m_data_axis_tvalid <= 1'b0;
      m_data_axis_tlast  <= 1'b0;
      m_data_axis_tdata  <= '0;
      m_data_axis_tkeep  <= '0;
      m_data_axis_tuser  <= '0;
    end else if (data_load) begin
      m_data_axis_tvalid <= 1'b1;
      m_data_axis_tlast  <= s_axis_tlast;
      m_data_axis_tdata  <= s_axis_tdata;
      m_data_axis_tkeep  <= s_axis_tkeep;
      m_data_axis_tuser  <= fwd_tuser;
    end else if (m_data_axis_tready) begin
      m_data_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      m_ctrl_axis_tvalid <= 1'b0;
      m_ctrl_axis_tlast  <= 1'b0;
      m_ctrl_axis_tdata  <= '0;
      m_ctrl_axis_tkeep  <= '0;
      m_ctrl_axis_tuser  <= '0;
    end else if (ctrl_load) begin
      m_ctrl_axis_tvalid <= 1'b1;
      m_ctrl_axis_tlast  <= s_axis_tlast;
      m_ctrl_axis_tdata  <= s_axis_tdata;
      m_ctrl_axis_tkeep  <= s_axis_tkeep;
      m_ctrl_axis_tuser  <= fwd_tuser;
    end else if (m_ctrl_axis_tready) begin
      m_ctrl_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      data_pkt_cnt <= '0;
      ctrl_pkt_cnt <= '0;
      drop_pkt_cnt <= '0;
    end else if (accept && sop) begin
      case (sop_cls)
        CLS_DATA: data_pkt_cnt <= data_pkt_cnt + CNT_WIDTH'(1);
        CLS_CTRL: ctrl_pkt_cnt <= ctrl_pkt_cnt + CNT_WIDTH'(1);
        default:  drop_pkt_cnt <= drop_pkt_cnt + CNT_WIDTH'(1);
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_ingress_classifier.sv
// tb/tb_pkt_ingress_classifier.sv - directed bench for pkt_ingress_classifier.
module tb_pkt_ingress_classifier;

  logic         clk = 1'b0;
  logic         areset;
  logic [511:0] s_tdata;
  logic [63:0]  s_tkeep;
  logic [127:0] s_tuser;
  logic         s_tvalid, s_tready, s_tlast;
  logic [511:0] d_tdata, c_tdata;
  logic [63:0]  d_tkeep, c_tkeep;
  logic [127:0] d_tuser, c_tuser;
  logic         d_tvalid, d_tlast, d_tready;
  logic         c_tvalid, c_tlast, c_tready;
  logic [31:0]  data_cnt, ctrl_cnt, drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] KALL = 64'hffff_ffff_ffff_ffff;

  pkt_ingress_classifier dut (
    .clk(clk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_data_axis_tdata(d_tdata), .m_data_axis_tkeep(d_tkeep), .m_data_axis_tuser(d_tuser),
    .m_data_axis_tvalid(d_tvalid), .m_data_axis_tlast(d_tlast), .m_data_axis_tready(d_tready),
    .m_ctrl_axis_tdata(c_tdata), .m_ctrl_axis_tkeep(c_tkeep), .m_ctrl_axis_tuser(c_tuser),
    .m_ctrl_axis_tvalid(c_tvalid), .m_ctrl_axis_tlast(c_tlast), .m_ctrl_axis_tready(c_tready),
    .data_pkt_cnt(data_cnt), .ctrl_pkt_cnt(ctrl_cnt), .drop_pkt_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] hdr(input logic [15:0] et, input logic [15:0] it,
                                       input logic [7:0] pr, input logic [15:0] dp);
    logic [511:0] d;
    d = {64{8'h5a}};
    d[12*8 +: 8] = et[15:8];
    d[13*8 +: 8] = et[7:0];
    d[16*8 +: 8] = it[15:8];
    d[17*8 +: 8] = it[7:0];
    d[27*8 +: 8] = pr;
    d[40*8 +: 8] = dp[15:8];
    d[41*8 +: 8] = dp[7:0];
    return d;
  endfunction

  function automatic logic [511:0] fill(input logic [7:0] b);
    logic [511:0] d;
    d = {64{b}};
    return d;
  endfunction

  task automatic drive(input logic [511:0] d, input logic [63:0] k, input logic [127:0] u,
                       input logic l);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tuser  = u;
    s_tlast  = l;
  endtask

  logic [511:0] h_ctrl, h_data, h_drop;

  initial begin
    h_ctrl = hdr(16'h8100, 16'h0800, 8'h11, 16'hf1f2);
    h_data = hdr(16'h8100, 16'h0800, 8'h11, 16'h0100);
    h_drop = hdr(16'h0800, 16'h0800, 8'h11, 16'hf1f2);

    areset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = 1'b0;
    d_tready = 1'b1; c_tready = 1'b1;
    tick(); tick();
    chk("rst_s_tready", s_tready, 0);
    chk("rst_d_tvalid", d_tvalid, 0);
    chk("rst_c_tvalid", c_tvalid, 0);
    chk("rst_d_tdata", d_tdata, 0);
    chk("rst_cnts", {drop_cnt, ctrl_cnt, data_cnt}, 0);
    areset = 1'b0;

    // CTRL packet, 2 beats
    drive(h_ctrl, KALL, 128'h10042, 1'b0);
    #1 chk("t1_s_tready", s_tready, 1);
    tick();
    chk("t1_b1_c_tvalid", c_tvalid, 1);
    chk("t1_b1_c_tdata", c_tdata, h_ctrl);
    chk("t1_b1_c_tuser", c_tuser, 128'h10042);
    chk("t1_b1_c_tlast", c_tlast, 0);
    chk("t1_b1_d_tvalid", d_tvalid, 0);
    chk("t1_ctrl_cnt", ctrl_cnt, 1);
    drive(fill(8'hc2), 64'h3, 128'hdead, 1'b1);
    tick();
    chk("t1_b2_c_tdata", c_tdata, fill(8'hc2));
    chk("t1_b2_c_tkeep", c_tkeep, 64'h3);
    chk("t1_b2_c_tuser", c_tuser, 0);
    chk("t1_b2_c_tlast", c_tlast, 1);
    chk("t1_b2_d_tvalid", d_tvalid, 0);
    s_tvalid = 1'b0;
    tick();
    chk("t1_c_idle", c_tvalid, 0);

    // DATA packet, 3 beats; beat 2 looks like a CTRL header but must stay DATA
    drive(h_data, KALL, 128'h77, 1'b0);
    tick();
    chk("t2_b1_d_tvalid", d_tvalid, 1);
    chk("t2_b1_d_tuser", d_tuser, 128'h77);
    chk("t2_b1_d_tlast", d_tlast, 0);
    chk("t2_data_cnt", data_cnt, 1);
    drive(h_ctrl, KALL, 128'h0, 1'b0);
    tick();
    chk("t2_b2_d_tdata", d_tdata, h_ctrl);
    chk("t2_b2_c_tvalid", c_tvalid, 0);
    chk("t2_b2_d_tlast", d_tlast, 0);
    drive(fill(8'hd3), 64'h7fff, 128'h0, 1'b1);
    tick();
    chk("t2_b3_d_tdata", d_tdata, fill(8'hd3));
    chk("t2_b3_d_tkeep", d_tkeep, 64'h7fff);
    chk("t2_b3_d_tlast", d_tlast, 1);
    chk("t2_ctrl_cnt", ctrl_cnt, 1);
    s_tvalid = 1'b0;
    tick();
    chk("t2_d_idle", d_tvalid, 0);

    // Non-VLAN packet is dropped
    drive(h_drop, KALL, 128'h5, 1'b1);
    #1 chk("t3_s_tready", s_tready, 1);
    tick();
    chk("t3_d_tvalid", d_tvalid, 0);
    chk("t3_c_tvalid", c_tvalid, 0);
    chk("t3_drop_cnt", drop_cnt, 1);
    s_tvalid = 1'b0;

    // DATA packet under back-pressure
    d_tready = 1'b0;
    drive(h_data, KALL, 128'h99, 1'b0);
    #1 chk("t4_s_tready_empty", s_tready, 1);
    tick();
    drive(fill(8'hb2), KALL, 128'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_s_tready", s_tready, 0);
      chk("t4_hold_d_tvalid", d_tvalid, 1);
      chk("t4_hold_d_tdata", d_tdata, h_data);
      chk("t4_hold_d_tuser", d_tuser, 128'h99);
      tick();
    end
    d_tready = 1'b1;
    #1 chk("t4_release_s_tready", s_tready, 1);
    tick();
    chk("t4_b2_d_tdata", d_tdata, fill(8'hb2));
    chk("t4_b2_d_tuser", d_tuser, 0);
    drive(fill(8'hb3), KALL, 128'h0, 1'b0);
    tick();
    chk("t4_b3_d_tdata", d_tdata, fill(8'hb3));
    chk("t4_b3_d_tlast", d_tlast, 0);
    drive(fill(8'hb4), 64'hff, 128'h0, 1'b1);
    tick();
    chk("t4_b4_d_tdata", d_tdata, fill(8'hb4));
    chk("t4_b4_d_tlast", d_tlast, 1);
    s_tvalid = 1'b0;
    tick();
    chk("t4_d_idle", d_tvalid, 0);
    chk("t4_data_cnt", data_cnt, 2);

    // Back-to-back single-beat packets: CTRL, DATA, CTRL
    drive(h_ctrl, KALL, 128'ha1, 1'b1);
    tick();
    chk("t5_p1_c_tvalid", c_tvalid, 1);
    chk("t5_p1_d_tvalid", d_tvalid, 0);
    chk("t5_p1_c_tuser", c_tuser, 128'ha1);
    drive(h_data, KALL, 128'ha2, 1'b1);
    tick();
    chk("t5_p2_d_tvalid", d_tvalid, 1);
    chk("t5_p2_c_tvalid", c_tvalid, 0);
    chk("t5_p2_d_tuser", d_tuser, 128'ha2);
    chk("t5_p2_d_tlast", d_tlast, 1);
    drive(h_ctrl, KALL, 128'ha3, 1'b1);
    tick();
    chk("t5_p3_c_tvalid", c_tvalid, 1);
    chk("t5_p3_d_tvalid", d_tvalid, 0);
    chk("t5_p3_c_tuser", c_tuser, 128'ha3);
    s_tvalid = 1'b0;
    tick();
    chk("t5_ctrl_cnt", ctrl_cnt, 3);
    chk("t5_data_cnt", data_cnt, 3);
    chk("t5_drop_cnt", drop_cnt, 1);

    // Reset during beat 2 of a DATA packet, then a CTRL packet
    drive(h_data, KALL, 128'h1, 1'b0);
    tick();
    chk("t6_b1_d_tvalid", d_tvalid, 1);
    drive(fill(8'he2), KALL, 128'h0, 1'b0);
    areset = 1'b1;
    #1 chk("t6_rst_s_tready", s_tready, 0);
    tick();
    areset = 1'b0;
    chk("t6_rst_d_tvalid", d_tvalid, 0);
    chk("t6_rst_d_tlast", d_tlast, 0);
    chk("t6_rst_d_tdata", d_tdata, 0);
    chk("t6_rst_d_tuser", d_tuser, 0);
    chk("t6_rst_cnts", {drop_cnt, ctrl_cnt, data_cnt}, 0);
    drive(h_ctrl, KALL, 128'hbeef, 1'b1);
    tick();
    chk("t6_c_tvalid", c_tvalid, 1);
    chk("t6_c_tuser", c_tuser, 128'hbeef);
    chk("t6_c_tlast", c_tlast, 1);
    chk("t6_d_tvalid", d_tvalid, 0);
    chk("t6_ctrl_cnt", ctrl_cnt, 1);
    chk("t6_data_cnt", data_cnt, 0);
    s_tvalid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_ingress_classifier.md
Name: pkt_ingress_classifier

Overview:
- Sits directly upstream of rmt_wrapper; consumes the 512-bit ingress AXI-Stream from the MAC/DMA side.
- Classifies each packet on its first beat into one of three classes: DATA (to rmt_wrapper), CTRL (to the reconfiguration path), or DROP.
- Forwards whole packets through one registered output stage per port.
- Exposes per-class packet counters.

Parameters:
- C_S_AXIS_DATA_WIDTH, 512, data width for all streams; byte offsets below assume 512.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width for all streams.
- CTRL_UDP_PORT, 16'hf1f2, UDP destination port that marks a control packet.
- CNT_WIDTH, 32, counter width.

Ports:
- clk  in  1  single clock.
- areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  512  ingress data.
- s_axis_tkeep  in  64  ingress byte enables.
- s_axis_tuser  in  128  ingress metadata, valid on the first beat.
- s_axis_tvalid  in  1  ingress valid.
- s_axis_tready  out  1  ingress ready.
- s_axis_tlast  in  1  ingress end of packet.
- m_data_axis_tdata/tkeep/tuser/tvalid/tlast  out  512/64/128/1/1  DATA stream to rmt_wrapper.
- m_data_axis_tready  in  1  DATA ready.
- m_ctrl_axis_tdata/tkeep/tuser/tvalid/tlast  out  512/64/128/1/1  CTRL stream.
- m_ctrl_axis_tready  in  1  CTRL ready.
- data_pkt_cnt  out  CNT_WIDTH  DATA packets accepted.
- ctrl_pkt_cnt  out  CNT_WIDTH  CTRL packets accepted.
- drop_pkt_cnt  out  CNT_WIDTH  DROP packets accepted.

Behaviour:
- Byte k of tdata is tdata[8k+7:8k]. On the first beat the block extracts:
  - ethertype = {b12,b13}
  - inner type = {b16,b17}
  - IP proto = b27
  - UDP dport = {b40,b41}
- Classification:
  - CTRL: ethertype==16'h8100, inner type==16'h0800, proto==8'h11 and dport==CTRL_UDP_PORT.
  - DATA: ethertype==16'h8100 and not CTRL.
  - DROP: anything else.
- FSM states IDLE, FWD_DATA, FWD_CTRL, DROP. All states return to IDLE on an accepted beat with tlast.
  - IDLE: the beat is the SOP. The class is decoded combinationally.
  - An SOP beat with tlast=1 stays in IDLE.
  - Otherwise IDLE moves to FWD_DATA, FWD_CTRL or DROP according to the class.
  - The class is held until tlast; non-SOP beats are never reclassified.
- Output stage, one per port: a single register (valid/data/keep/user/last).
  - Latency is 1 cycle from input acceptance to tvalid.
  - The stage loads when empty or when its tready=1 in the same cycle.
  - tvalid is cleared when the beat is consumed and nothing new loads.
  - Holding rules are AXI-Stream compliant: payload is stable while tvalid=1 and tready=0.
- m_*_tuser carries s_axis_tuser on the SOP beat and 0 on later beats.
- s_axis_tready:
  - Selected port DATA or CTRL: ~out_valid | out_tready of that port.
  - DROP: 1. Dropped beats are consumed and discarded.
  - In IDLE the selection uses the current SOP decode.
- Back-pressure on one port never blocks a beat already committed to the other port.
- Counters increment by 1 on acceptance of the SOP beat of the respective class. They wrap at 2^CNT_WIDTH.
- Reset:
  - All tvalid, tlast, tdata, tkeep and tuser outputs = 0.
  - Counters = 0.
  - FSM = IDLE.
  - s_axis_tready = 0 while areset=1.
- Reset mid-packet: the partial packet is abandoned and no tlast is emitted. The first valid beat after reset is treated as SOP.
- s_axis_tvalid with tkeep=0 on a non-last beat is forwarded unchanged; no tkeep checking is done.

Test Plan:
- VLAN/UDP packet, b12..13=81 00, b27=11, dport b40..41=f1 f2, 2 beats (second tkeep=64'h3) -> both beats on m_ctrl one cycle later; tuser 128'h10042 on beat 1 only; ctrl_pkt_cnt=1; m_data_axis_tvalid stays 0.
- Same packet with dport=16'h0100, 3 beats (last tkeep=64'h7fff) -> 3 beats on m_data, tlast on beat 3 only; data_pkt_cnt=1.
- Non-VLAN packet, ethertype 16'h0800, 1 beat with tlast -> no output valid; s_axis_tready=1 throughout; drop_pkt_cnt=1.
- DATA packet streaming with m_data_axis_tready held 0 for 5 cycles -> s_axis_tready=0 after the one buffered beat; output payload stable; all beats delivered once in order after release.
- Back-to-back single-beat packets CTRL, DATA, CTRL with both treadies=1 -> one per cycle, correct port each, ctrl_pkt_cnt=2, data_pkt_cnt=1.
- areset asserted for 1 cycle during beat 2 of a 4-beat DATA packet, then a new CTRL packet -> outputs and counters 0 after reset; the new packet is routed to CTRL as SOP; ctrl_pkt_cnt=1.
